mc_idle_monitor: RTL and testbench
==================================

MC_IDLE_MONITOR -- requirements
Module: mc_idle_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the idle counter and of idle_threshold.
REQ-002 Parameter NOP_CMD, default 4'b0000: command code that does not count as activity.
REQ-003 Parameter PD_CMD, default 4'b0100: power-down entry code driven on cmd_type.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port cmd_valid  input  1  scheduler command strobe.
REQ-007 Port cmd_in  input  4  scheduler command code; meaningful when cmd_valid=1.
REQ-008 Port queue_nonempty  input  1  request queue holds at least one entry.
REQ-009 Port refresh_pending  input  1  refresh is due; blocks power-down issue.
REQ-010 Port pd_enable  input  1  power-down entry permitted.
REQ-011 Port idle_threshold  input  CNT_W  idle cycles required before power-down entry; 0 disables entry.
REQ-012 Port activity_detected  output  1  registered activity flag to the power-management stage.
REQ-013 Port cmd_type  output  4  registered command code to the power-management stage.
REQ-014 Port pd_hold  output  1  high while the block is in the HOLD state.
REQ-015 Port idle_count  output  CNT_W  current idle counter value.
REQ-016 Port pd_entries  output  8  count of power-down commands issued; wraps 255->0.

Function
REQ-017 act_now SHALL be (cmd_valid AND cmd_in!=NOP_CMD) OR queue_nonempty, evaluated combinationally each cycle.
REQ-018 activity_detected SHALL equal act_now delayed by one cycle.
REQ-019 The state machine SHALL have four states: BUSY, COUNT, ISSUE and HOLD.
REQ-020 In BUSY: act_now -> stay in BUSY with idle_count=0; else -> COUNT with idle_count=1.
REQ-021 In COUNT with act_now=1: go to BUSY and load idle_count=0.
REQ-022 In COUNT with act_now=0 and issue_ok: go to ISSUE; issue_ok = idle_count==idle_threshold AND idle_threshold!=0 AND pd_enable AND NOT refresh_pending.
REQ-023 In COUNT with act_now=0 and NOT issue_ok: stay in COUNT and increment idle_count, saturating at all-ones.
REQ-024 If idle_count already exceeds idle_threshold (threshold lowered mid-count), the block SHALL treat idle_count>=idle_threshold as satisfying the count term of issue_ok.
REQ-025 ISSUE SHALL last exactly one cycle, then go to HOLD; if act_now=1 during that cycle it SHALL go to BUSY instead; activity wins.
REQ-026 In HOLD: act_now=1 -> go to BUSY with idle_count=0; else stay in HOLD; idle_count frozen.
REQ-027 cmd_type register: loaded with PD_CMD on entry to ISSUE, so it reads PD_CMD for exactly the one cycle the state is ISSUE.
REQ-028 In all other cycles, cmd_type SHALL load cmd_in if cmd_valid=1, else NOP_CMD.
REQ-029 pd_entries SHALL increment by 1, modulo 256, on every transition into ISSUE.
REQ-030 pd_hold SHALL be 1 exactly when the state is HOLD.
REQ-031 Deasserting pd_enable or asserting refresh_pending in COUNT SHALL block the ISSUE transition only; counting continues and entry occurs on the first cycle the block clears.

Reset
REQ-032 While reset_n=0: state=BUSY, idle_count=0, activity_detected=0, cmd_type=NOP_CMD, pd_hold=0, pd_entries=0, asynchronously.
REQ-033 Reset asserted mid-operation, including in ISSUE or HOLD, SHALL abort immediately with no PD_CMD emitted afterwards.
REQ-034 After reset_n rises, the first state update SHALL occur on the next rising clk edge.

Verification
REQ-035 Threshold 8, pd_enable=1, inputs idle after one command -> cmd_type=4'b0100 for exactly one cycle, then pd_hold=1 and pd_entries=1.
REQ-036 Threshold 8, queue_nonempty pulsed at idle_count=5 -> idle_count returns to 0 and no PD_CMD is emitted.
REQ-037 refresh_pending=1 when idle_count reaches 8, released 3 cycles later -> ISSUE occurs on the release cycle and idle_count reads 11.
REQ-038 In HOLD, cmd_valid=1 with cmd_in=4'b0001 -> activity_detected=1 one cycle later, state BUSY, and cmd_type=4'b0001.
REQ-039 Force 256 entries -> pd_entries wraps to 0; idle_threshold=0 held for 100k idle cycles -> no PD_CMD, and idle_count saturates if CNT_W is small.
REQ-040 Reset_n pulsed low during ISSUE -> all outputs at reset values immediately, and cmd_type does not show 4'b0100 afterwards.

Source files
------------

// File: rtl/mc_idle_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mc_idle_monitor
//  Description : Memory-controller idle monitor. It watches scheduler command
//                traffic and the request queue, counts consecutive idle
//                cycles and issues a single power-down command once the
//                programmed idle threshold is met. It then holds in power-down
//                until activity returns.
//
//  Ports
//    clk               : sole clock, rising edge
//    reset_n           : asynchronous active-low reset
//    cmd_valid         : scheduler command strobe
//    cmd_in[3:0]       : scheduler command code (meaningful with cmd_valid)
//    queue_nonempty    : request queue holds at least one entry
//    refresh_pending   : refresh due; blocks power-down issue
//    pd_enable         : power-down entry permitted
//    idle_threshold    : idle cycles required before entry (0 disables)
//    activity_detected : registered activity flag
//    cmd_type[3:0]     : registered command code to the power-management stage
//    pd_hold           : high while holding in power-down
//    idle_count        : current idle counter value
//    pd_entries[7:0]   : power-down commands issued, wraps 255->0
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_idle_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [3:0]  NOP_CMD = 4'b0000,
    parameter logic [3:0]  PD_CMD  = 4'b0100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd_in,
    input  logic             queue_nonempty,
    input  logic             refresh_pending,
    input  logic             pd_enable,
    input  logic [CNT_W-1:0] idle_threshold,
    output logic             activity_detected,
    output logic [3:0]       cmd_type,
    output logic             pd_hold,
    output logic [CNT_W-1:0] idle_count,
    output logic [7:0]       pd_entries
);

    // State encoding
    localparam logic [1:0] c_BUSY  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_ISSUE = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_idle_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_act_now;
    logic             w_issue_ok;
    logic             w_enter_issue;
    logic             r_activity;
    logic [3:0]       r_cmd_type;
    logic [7:0]       r_pd_entries;

    // A NOP strobe is not activity; a non-empty queue always is.
    assign w_act_now = (cmd_valid && (cmd_in != NOP_CMD)) || queue_nonempty;

    // ">=" rather than "==" so that lowering the threshold below the running
    // count still lets entry happen instead of stalling until saturation.
    assign w_issue_ok = (r_idle_count >= idle_threshold) &&
                        (idle_threshold != '0) &&
                        pd_enable && !refresh_pending;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_idle_count;
        case (r_state)
            c_BUSY: begin
                if (w_act_now) begin
                    w_state_nxt = c_BUSY;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = c_COUNT;
                    w_count_nxt = c_CNT_ONE;
                end
            end
            c_COUNT: begin
                if (w_act_now) begin
                    w_state_nxt = c_BUSY;
                    w_count_nxt = '0;
                end else if (w_issue_ok) begin
                    // Count is held while the power-down command goes out.
                    w_state_nxt = c_ISSUE;
                end else if (r_idle_count != c_CNT_MAX) begin
                    w_count_nxt = r_idle_count + c_CNT_ONE;
                end
            end
            c_ISSUE: begin
                // Activity during the issue cycle wins over entering HOLD.
                if (w_act_now) begin
                    w_state_nxt = c_BUSY;
                    w_count_nxt = '0;
                end else begin
                    w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                if (w_act_now) begin
                    w_state_nxt = c_BUSY;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = c_BUSY;
                w_count_nxt = '0;
            end
        endcase
    end

    // Only COUNT can lead to ISSUE, and ISSUE never repeats itself.
    assign w_enter_issue = (w_state_nxt == c_ISSUE) && (r_state != c_ISSUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_BUSY;
            r_idle_count <= '0;
            r_activity   <= 1'b0;
            r_cmd_type   <= NOP_CMD;
            r_pd_entries <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idle_count <= w_count_nxt;
            r_activity   <= w_act_now;
            // PD_CMD overrides any concurrent (necessarily NOP) strobe so it
            // is visible for exactly the single ISSUE cycle.
            if (w_enter_issue) begin
                r_cmd_type   <= PD_CMD;
                r_pd_entries <= r_pd_entries + 8'd1;
            end else if (cmd_valid) begin
                r_cmd_type   <= cmd_in;
            end else begin
                r_cmd_type   <= NOP_CMD;
            end
        end
    end

    assign activity_detected = r_activity;
    assign cmd_type          = r_cmd_type;
    assign pd_hold           = (r_state == c_HOLD);
    assign idle_count        = r_idle_count;
    assign pd_entries        = r_pd_entries;

endmodule
`default_nettype wire

// File: tb/tb_mc_idle_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mc_idle_monitor
//  Description : Scoreboard bench for mc_idle_monitor. The stimulus process
//                runs a behavioural model and queues the expected outputs;
//                a monitor process pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_idle_monitor;

    localparam int         CNT_W   = 6;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [3:0] NOP     = 4'b0000;
    localparam logic [3:0] PD      = 4'b0100;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [3:0]       cmd_in = 4'd0;
    logic             queue_nonempty = 1'b0;
    logic             refresh_pending = 1'b0;
    logic             pd_enable = 1'b0;
    logic [CNT_W-1:0] idle_threshold = '0;
    logic             activity_detected;
    logic [3:0]       cmd_type;
    logic             pd_hold;
    logic [CNT_W-1:0] idle_count;
    logic [7:0]       pd_entries;

    mc_idle_monitor #(.CNT_W(CNT_W), .NOP_CMD(NOP), .PD_CMD(PD)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_in            (cmd_in),
        .queue_nonempty    (queue_nonempty),
        .refresh_pending   (refresh_pending),
        .pd_enable         (pd_enable),
        .idle_threshold    (idle_threshold),
        .activity_detected (activity_detected),
        .cmd_type          (cmd_type),
        .pd_hold           (pd_hold),
        .idle_count        (idle_count),
        .pd_entries        (pd_entries)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       act;
        logic [3:0] cmd;
        logic       hold;
        int         cnt;
        int         entries;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, req);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 = active, 1 = counting idle, 2 = issuing PD, 3 = powered down
    int m_phase;
    int m_cnt;
    int m_entries;

    task automatic model_reset();
        m_phase   = 0;
        m_cnt     = 0;
        m_entries = 0;
    endtask

    task automatic drive(input bit cv, input logic [3:0] ci, input bit qn,
                         input bit rp, input bit pe, input int thr);
        exp_t e;
        bit   act;
        bit   fire;
        cmd_valid       = cv;
        cmd_in          = ci;
        queue_nonempty  = qn;
        refresh_pending = rp;
        pd_enable       = pe;
        idle_threshold  = CNT_W'(thr);
        act  = (cv && ci != NOP) || qn;
        fire = 0;
        if (act) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_cnt   = 1;
        end else if (m_phase == 1) begin
            if (thr != 0 && m_cnt >= thr && pe && !rp) begin
                m_phase = 2;
                fire    = 1;
            end else if (m_cnt < CNT_MAX) begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_phase == 2) begin
            m_phase = 3;
        end
        if (fire) m_entries = (m_entries + 1) % 256;
        e.due     = cyc + 1;
        e.act     = act;
        e.cmd     = fire ? PD : (cv ? ci : NOP);
        e.hold    = (m_phase == 3);
        e.cnt     = m_cnt;
        e.entries = m_entries;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rp, input bit pe, input int thr);
        for (int i = 0; i < n; i++) drive(1'b0, NOP, 1'b0, rp, pe, thr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_act"},     32'(activity_detected), 32'd0);
        chk({tag, "_cmd"},     32'(cmd_type),          32'(NOP));
        chk({tag, "_hold"},    32'(pd_hold),           32'd0);
        chk({tag, "_cnt"},     32'(idle_count),        32'd0);
        chk({tag, "_entries"}, 32'(pd_entries),        32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                if (e.due != cyc) chk("sb_due", 32'(e.due), 32'(cyc));
                chk("activity_detected", 32'(activity_detected), 32'(e.act));
                chk("cmd_type",          32'(cmd_type),          32'(e.cmd));
                chk("pd_hold",           32'(pd_hold),           32'(e.hold));
                chk("idle_count",        32'(idle_count),        32'(e.cnt));
                chk("pd_entries",        32'(pd_entries),        32'(e.entries));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int  n;
        int  thr;
        bit  cv;
        bit  qn;
        bit  rp;
        bit  pe;
        logic [3:0] ci;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // One command then idle: single PD cycle, then HOLD with one entry
        drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 8);
        idle(12, 1'b0, 1'b1, 8);

        // Command in HOLD wakes the block
        drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 8);
        idle(1, 1'b0, 1'b1, 8);

        // Queue pulse at idle_count 5 restarts counting, no PD
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 8);
        idle(5, 1'b0, 1'b1, 8);
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 8);
        idle(3, 1'b0, 1'b1, 8);

        // Refresh blocks entry at count 8 for three cycles; entry at 11
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 8);
        n = 0;
        while (m_cnt < 8 && n < 20) begin
            drive(1'b0, NOP, 1'b0, 1'b0, 1'b1, 8);
            n++;
        end
        chk("reach_count_8", 32'(m_cnt), 32'd8);
        idle(3, 1'b1, 1'b1, 8);
        idle(3, 1'b0, 1'b1, 8);

        // Threshold lowered below the running count
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 20);
        idle(15, 1'b0, 1'b1, 20);
        idle(3, 1'b0, 1'b1, 5);

        // Reset pulsed during ISSUE aborts immediately
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 3);
        n = 0;
        while (m_phase != 2 && n < 20) begin
            drive(1'b0, NOP, 1'b0, 1'b0, 1'b1, 3);
            n++;
        end
        chk("reach_issue", 32'(m_phase), 32'd2);
        #1;
        chk("issue_cmd_type", 32'(cmd_type), 32'(PD));
        sbq.delete();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk("reset_held_cmd", 32'(cmd_type), 32'(NOP));
        reset_n = 1'b1;
        model_reset();
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 3);
        idle(2, 1'b0, 1'b1, 3);

        // Threshold 0 disables entry; counter saturates
        drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 0);
        idle(100, 1'b0, 1'b1, 0);
        chk("saturated_model", 32'(m_cnt), 32'(CNT_MAX));

        // Force entries until pd_entries wraps back to 0
        n = 0;
        do begin
            drive(1'b0, NOP, 1'b1, 1'b0, 1'b1, 1);
            idle(3, 1'b0, 1'b1, 1);
            n++;
        end while (m_entries != 0 && n < 300);
        chk("wrap_entries_model", 32'(m_entries), 32'd0);

        // Randomized traffic
        thr = 4;
        for (int i = 0; i < 1500; i++) begin
            cv = ($urandom_range(0, 99) < 10);
            ci = 4'($urandom_range(0, 15));
            qn = ($urandom_range(0, 99) < 4);
            rp = ($urandom_range(0, 99) < 15);
            pe = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 63) == 0) thr = $urandom_range(0, 12);
            drive(cv, ci, qn, rp, pe, thr);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
